// File: rtl/fetch_if.sv
// Fetch-stage bundle: pipeline control, instruction-memory port and IF/ID outputs.
// The master side is the surrounding pipeline/testbench, the slave side is fetch_stage.
interface fetch_if;
  logic        stall;
  logic        flush;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] imem_rdata;
  logic [15:0] imem_addr;
  logic [15:0] pc;
  logic [15:0] ifid_instr;
  logic [15:0] ifid_pc_plus2;
  logic        ifid_valid;
  logic        halted;
  logic [15:0] fetch_count;

  modport master (
    output stall, flush, redirect, redirect_pc, imem_rdata,
    input  imem_addr, pc, ifid_instr, ifid_pc_plus2, ifid_valid, halted, fetch_count
  );

  modport slave (
    input  stall, flush, redirect, redirect_pc, imem_rdata,
    output imem_addr, pc, ifid_instr, ifid_pc_plus2, ifid_valid, halted, fetch_count
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and a RUN/HALT
// state machine that parks fetch on a HLT opcode until a redirect arrives.
module fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [3:0]  HLT_OPC  = 4'hF
) (
  input logic   clk,
  input logic   rst,
  fetch_if.slave bus
);

  typedef enum logic {RUN, HALT} state_t;

  state_t      state;
  logic [15:0] pc_q;
  logic [15:0] instr_q;
  logic [15:0] pc_plus2_q;
  logic        valid_q;
  logic        halted_q;
  logic [15:0] count_q;

  logic [15:0] pc_plus2;
  logic        is_hlt;

  assign pc_plus2 = pc_q + 16'd2;
  assign is_hlt   = (bus.imem_rdata[15:12] == HLT_OPC);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RUN;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      pc_plus2_q <= '0;
      valid_q    <= 1'b0;
      halted_q   <= 1'b0;
      count_q    <= '0;
    end else if (bus.redirect) begin
      // Redirect beats stall and HALT; squashes anything fetched in the shadow.
      state    <= RUN;
      halted_q <= 1'b0;
      pc_q     <= {bus.redirect_pc[15:1], 1'b0};
      valid_q  <= 1'b0;
    end else if (bus.stall) begin
      if (bus.flush)
        valid_q <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          instr_q    <= bus.imem_rdata;
          pc_plus2_q <= pc_plus2;
          valid_q    <= ~bus.flush;
          if (!bus.flush && count_q != 16'hFFFF)
            count_q <= count_q + 16'd1;
          if (is_hlt) begin
            state    <= HALT;
            halted_q <= 1'b1;
          end else begin
            pc_q <= pc_plus2;
          end
        end
        HALT: begin
          valid_q <= 1'b0;
        end
        default: begin
          state    <= RUN;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_addr     = pc_q;
  assign bus.pc            = pc_q;
  assign bus.ifid_instr    = instr_q;
  assign bus.ifid_pc_plus2 = pc_plus2_q;
  assign bus.ifid_valid    = valid_q;
  assign bus.halted        = halted_q;
  assign bus.fetch_count   = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, reset corner cases,
// then randomized traffic against a behavioural model of the fetch rules.
module tb_fetch_stage;

  logic clk;
  logic rst;
  fetch_if bus ();

  fetch_stage #(.RESET_PC(16'h0000), .HLT_OPC(4'hF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        stall;
    logic        flush;
    logic        redirect;
    logic [15:0] rpc;
    logic [15:0] rdata;
    logic [15:0] pc;
    logic [15:0] instr;
    logic [15:0] pp2;
    logic        v;
    logic        h;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl [22];

  // reference model state
  logic [15:0] m_pc, m_instr, m_pp2, m_cnt;
  logic        m_v, m_h;

  task automatic check(input string name, input logic [15:0] pc, input logic [15:0] instr,
                       input logic [15:0] pp2, input logic v, input logic h, input logic [15:0] cnt);
    logic [81:0] act, exp;
    act = {bus.pc, bus.imem_addr, bus.ifid_instr, bus.ifid_pc_plus2, bus.ifid_valid, bus.halted, bus.fetch_count};
    exp = {pc, pc, instr, pp2, v, h, cnt};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got pc=%h addr=%h instr=%h pp2=%h v=%b h=%b cnt=%h, want pc=%h addr=%h instr=%h pp2=%h v=%b h=%b cnt=%h",
               name, bus.pc, bus.imem_addr, bus.ifid_instr, bus.ifid_pc_plus2, bus.ifid_valid,
               bus.halted, bus.fetch_count, pc, pc, instr, pp2, v, h, cnt);
    end
  endtask

  task automatic drive(input logic s, input logic f, input logic r, input logic [15:0] rpc, input logic [15:0] rd);
    bus.stall       = s;
    bus.flush       = f;
    bus.redirect    = r;
    bus.redirect_pc = rpc;
    bus.imem_rdata  = rd;
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_pc = 16'h0000; m_instr = '0; m_pp2 = '0; m_v = 1'b0; m_h = 1'b0; m_cnt = '0;
  endtask

  // One clock edge of the fetch rules, evaluated in priority order.
  task automatic model_edge(input logic s, input logic f, input logic r, input logic [15:0] rpc, input logic [15:0] rd);
    if (r) begin
      m_pc = {rpc[15:1], 1'b0};
      m_v  = 1'b0;
      m_h  = 1'b0;
    end else if (s) begin
      if (f) m_v = 1'b0;
    end else if (m_h) begin
      m_v = 1'b0;
    end else begin
      m_instr = rd;
      m_pp2   = m_pc + 16'd2;
      m_v     = !f;
      if (!f && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      if (rd[15:12] == 4'hF) m_h = 1'b1;
      else m_pc = m_pc + 16'd2;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    //          st fl rd  rpc       rdata      pc        instr     pp2       v  h  cnt
    tbl[0]  = '{0, 0, 0, 16'h0000, 16'h1234, 16'h0002, 16'h1234, 16'h0002, 1, 0, 16'd1};
    tbl[1]  = '{0, 0, 0, 16'h0000, 16'h1234, 16'h0004, 16'h1234, 16'h0004, 1, 0, 16'd2};
    tbl[2]  = '{0, 0, 0, 16'h0000, 16'h1234, 16'h0006, 16'h1234, 16'h0006, 1, 0, 16'd3};
    tbl[3]  = '{0, 0, 1, 16'h000E, 16'h9999, 16'h000E, 16'h1234, 16'h0006, 0, 0, 16'd3};
    tbl[4]  = '{0, 0, 0, 16'h0000, 16'h5555, 16'h0010, 16'h5555, 16'h0010, 1, 0, 16'd4};
    tbl[5]  = '{1, 0, 0, 16'h0000, 16'hAAAA, 16'h0010, 16'h5555, 16'h0010, 1, 0, 16'd4};
    tbl[6]  = '{1, 0, 0, 16'h0000, 16'hAAAA, 16'h0010, 16'h5555, 16'h0010, 1, 0, 16'd4};
    tbl[7]  = '{0, 0, 0, 16'h0000, 16'h6666, 16'h0012, 16'h6666, 16'h0012, 1, 0, 16'd5};
    tbl[8]  = '{1, 1, 0, 16'h0000, 16'h7777, 16'h0012, 16'h6666, 16'h0012, 0, 0, 16'd5};
    tbl[9]  = '{0, 0, 1, 16'h0021, 16'h7777, 16'h0020, 16'h6666, 16'h0012, 0, 0, 16'd5};
    tbl[10] = '{0, 0, 1, 16'h0041, 16'h8888, 16'h0040, 16'h6666, 16'h0012, 0, 0, 16'd5};
    tbl[11] = '{0, 0, 0, 16'h0000, 16'h4040, 16'h0042, 16'h4040, 16'h0042, 1, 0, 16'd6};
    tbl[12] = '{0, 1, 0, 16'h0000, 16'h1111, 16'h0044, 16'h1111, 16'h0044, 0, 0, 16'd6};
    tbl[13] = '{0, 0, 1, 16'h0030, 16'h2222, 16'h0030, 16'h1111, 16'h0044, 0, 0, 16'd6};
    tbl[14] = '{0, 0, 0, 16'h0000, 16'hF000, 16'h0030, 16'hF000, 16'h0032, 1, 1, 16'd7};
    tbl[15] = '{0, 0, 0, 16'h0000, 16'h1234, 16'h0030, 16'hF000, 16'h0032, 0, 1, 16'd7};
    tbl[16] = '{1, 0, 1, 16'h0100, 16'hF000, 16'h0100, 16'hF000, 16'h0032, 0, 0, 16'd7};
    tbl[17] = '{0, 0, 1, 16'hFFFE, 16'h0000, 16'hFFFE, 16'hF000, 16'h0032, 0, 0, 16'd7};
    tbl[18] = '{0, 0, 0, 16'h0000, 16'h2222, 16'h0000, 16'h2222, 16'h0000, 1, 0, 16'd8};
    tbl[19] = '{0, 1, 0, 16'h0000, 16'hF123, 16'h0000, 16'hF123, 16'h0002, 0, 1, 16'd8};
    tbl[20] = '{1, 0, 0, 16'h0000, 16'h3333, 16'h0000, 16'hF123, 16'h0002, 0, 1, 16'd8};
    tbl[21] = '{0, 1, 0, 16'h0000, 16'h3333, 16'h0000, 16'hF123, 16'h0002, 0, 1, 16'd8};

    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    #1;
    check("reset_state", 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'd0);
    do_reset();

    for (int i = 0; i < 22; i++) begin
      drive(tbl[i].stall, tbl[i].flush, tbl[i].redirect, tbl[i].rpc, tbl[i].rdata);
      edge_step();
      check($sformatf("vec%0d", i), tbl[i].pc, tbl[i].instr, tbl[i].pp2, tbl[i].v, tbl[i].h, tbl[i].cnt);
    end

    // Async reset pulsed between edges while halted, then refetch from RESET_PC.
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h1234);
    rst = 1'b1;
    #1;
    check("async_reset_halted", 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'd0);
    #1;
    rst = 1'b0;
    check("reset_release_hold", 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'd0);
    edge_step();
    check("first_fetch_after_reset", 16'h0002, 16'h1234, 16'h0002, 1'b1, 1'b0, 16'd1);

    // Randomized traffic against the model.
    do_reset();
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      logic s, f, r;
      logic [15:0] rpc, rd;
      s   = ($urandom_range(3) == 0);
      f   = ($urandom_range(5) == 0);
      r   = ($urandom_range(7) == 0);
      rpc = 16'($urandom);
      rd  = 16'($urandom);
      if ($urandom_range(9) == 0) rd[15:12] = 4'hF;
      else if (rd[15:12] == 4'hF) rd[15:12] = 4'h7;
      drive(s, f, r, rpc, rd);
      model_edge(s, f, r, rpc, rd);
      edge_step();
      check($sformatf("rand%0d", n), m_pc, m_instr, m_pp2, m_v, m_h, m_cnt);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
